fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the team's synchronous FIFO. It owns the read pointer and issues reads to the FIFO storage array, which has a 1-cycle synchronous read. Read data is presented on a registered valid/ready output port backed by a 2-entry skid stage. It is the consumer end of the write-side logic: it takes the write pointer in and returns the read pointer used for the full flag.

Parameters:
DATA_WIDTH, 8, width of each FIFO entry
ADDR_WIDTH, 4, storage address width; depth = 2**ADDR_WIDTH

Ports:
clk  input  1  clock
rst_  input  1  reset, asynchronous, active-low
wr_ptr  input  ADDR_WIDTH+1  write pointer from write side, same clock domain; binary, MSB is wrap bit
rd_ptr  output  ADDR_WIDTH+1  read pointer to write side (full detection)
mem_ren  output  1  storage read enable
mem_raddr  output  ADDR_WIDTH  storage read address = rd_ptr[ADDR_WIDTH-1:0]
mem_rdata  input  DATA_WIDTH  storage read data, valid the cycle after mem_ren
rd_data  output  DATA_WIDTH  head-of-FIFO data
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts rd_data
empty  output  1  no data in storage or in the output stage
level  output  ADDR_WIDTH+2  total unread entries (storage + in-flight + output stage)

Behaviour:
- Reset (async, rst_=0): rd_ptr=0, rd_data=0, rd_valid=0, inflight=0, skid empty, skid data=0. Derived outputs then read mem_ren=0, empty=1 when wr_ptr=0, level=wr_ptr.
- avail = (wr_ptr != rd_ptr). pop = rd_valid & rd_ready. occ = out_v + skid_v + inflight.
- mem_ren (combinational) = avail & ((occ - pop) < 2). On an issuing edge: rd_ptr <= rd_ptr+1, with natural wrap from 2**(ADDR_WIDTH+1)-1 to 0; inflight <= 1. Otherwise inflight <= 0.
- Output-stage FSM, one state per occupancy: S0 (out empty), S1 (out valid), S2 (out+skid valid). Data arriving via inflight goes:
  - to out if out is empty, or if out is being popped and skid is empty;
  - to skid otherwise.
  - On pop with skid valid: skid -> out, and any arriving word -> skid.
- Transitions:
  - S0->S1 on arrival.
  - S1->S1 on arrival&pop, or on no arrival & no pop.
  - S1->S0 on pop without arrival.
  - S1->S2 on arrival without pop.
  - S2->S1 on pop without arrival.
  - S2->S2 on pop with arrival.
  - Arrival in S2 without pop cannot happen: the issue rule guarantees it. The bench asserts this.
- rd_data and rd_valid are registered. rd_data holds stable while rd_valid & !rd_ready. Entries are delivered strictly in write order.
- Latency: wr_ptr change visible in cycle c -> mem_ren in c -> rd_valid=1 in c+2.
- Throughput: 1 word/cycle sustained with rd_ready=1.
- empty = !avail & (occ==0).
- level = (wr_ptr - rd_ptr mod 2**(ADDR_WIDTH+1)) + occ.
- rd_ptr advances at fetch, so the write side may refill the fetched slots; level can therefore reach depth+2.
- A pop with rd_valid=0 is ignored. No underflow state exists.
- Reset mid-operation: all buffered and in-flight data is discarded immediately. mem_rdata arriving after reset release is ignored because inflight=0.

Optional Feature:
Macro FIFO_RD_FLUSH_EN.
- Defined: adds input flush (1 bit, synchronous, active-high). On a clock edge with flush=1:
  - rd_ptr <= wr_ptr; out, skid and inflight are cleared; rd_valid <= 0.
  - mem_ren is forced 0 in that cycle.
  - flush overrides pop and arrival.
- Not defined: no flush port. Storage is drained only by reads.

Test Plan:
1. Reset: hold rst_=0 with wr_ptr=0 -> rd_valid=0, rd_data=0x00, rd_ptr=0, mem_ren=0, empty=1, level=0; release with wr_ptr=0 -> all unchanged.
2. Single word: mem[0]=0xA5, wr_ptr 0->1, rd_ready=1 -> mem_ren=1 with mem_raddr=0 that cycle; rd_valid=1 with rd_data=0xA5 two cycles later for exactly one cycle; rd_ptr=1; empty=1 afterwards.
3. Streaming with wrap: write-side model pushes 40 words 0x00..0x27 with rd_ready=1 -> one word/cycle in order, rd_ptr goes 31->0 and ends at 8, no gaps once started.
4. Backpressure: 4 words 0x10..0x13 written, rd_ready=0 -> exactly 2 reads issued, rd_ptr=2, rd_data=0x10 stable, level=4. Then rd_ready=1 -> 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
5. Toggling ready: rd_ready pattern 1,0,1,1,0 over 8 buffered words -> no loss, no duplication, in order; occ never exceeds 2 (assertion).
6. Reset mid-stream after 3 of 8 words popped -> rd_valid=0 immediately (async), rd_ptr=0. A late mem_rdata is not presented.
   With FIFO_RD_FLUSH_EN: flush at the same point -> rd_ptr=wr_ptr, rd_valid=0, level=0 next cycle.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side FIFO controller, 1-cycle sync storage read, 2-entry skid output stage.
// Optional synchronous flush input enabled by defining FIFO_RD_FLUSH_EN.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] level
`ifdef FIFO_RD_FLUSH_EN
    ,
    input  logic                  flush
`endif
);
    typedef enum logic [1:0] {S0, S1, S2} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] skid_data, out_n, skid_n;
    logic [ADDR_WIDTH:0] diff;
    logic [1:0] occ;
    logic inflight, avail, pop, fl;
`ifdef FIFO_RD_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    assign avail     = wr_ptr != rd_ptr;
    assign rd_valid  = state != S0;
    assign pop       = rd_valid & rd_ready;
    // state encoding equals output-stage occupancy
    assign occ       = 2'(state) + 2'(inflight);
    assign mem_ren   = !fl & avail & ((occ - 2'(pop)) < 2'd2);
    assign mem_raddr = rd_ptr[ADDR_WIDTH-1:0];
    assign empty     = !avail & (occ == 2'd0);
    assign diff      = wr_ptr - rd_ptr;
    assign level     = {1'b0, diff} + {{ADDR_WIDTH{1'b0}}, occ};
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= S0;
            rd_ptr    <= '0;
            inflight  <= 1'b0;
            rd_data   <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_n;
            rd_ptr    <= fl ? wr_ptr : rd_ptr + (ADDR_WIDTH+1)'(mem_ren);
            inflight  <= mem_ren;
            rd_data   <= out_n;
            skid_data <= skid_n;
        end
    end
    always_comb begin
        state_n = state;
        out_n   = rd_data;
        skid_n  = skid_data;
        if (fl) begin
            state_n = S0;
            out_n   = '0;
            skid_n  = '0;
        end else begin
            case (state)
                S0: if (inflight) begin
                    state_n = S1;
                    out_n   = mem_rdata;
                end
                S1: if (inflight) begin
                    if (pop) out_n = mem_rdata;
                    else begin
                        skid_n  = mem_rdata;
                        state_n = S2;
                    end
                end else if (pop) state_n = S0;
                S2: if (pop) begin
                    out_n = skid_data;
                    if (inflight) skid_n = mem_rdata;
                    else state_n = S1;
                end
                default: state_n = S0;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed table and sequence checks for fifo_rd_ctrl with a storage/write-side model.
module tb_fifo_rd_ctrl;
    logic clk = 1'b0, rst_ = 1'b0;
    logic [4:0] wr_ptr = '0, rd_ptr;
    logic mem_ren, rd_valid, empty, rd_ready = 1'b0;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata = '0, rd_data;
    logic [5:0] level;
    logic [7:0] mem [16];
    int checks = 0, errors = 0;
`ifdef FIFO_RD_FLUSH_EN
    logic flush = 1'b0;
`endif

    fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_(rst_), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .empty(empty), .level(level)
`ifdef FIFO_RD_FLUSH_EN
        , .flush(flush)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // an arrival while both output registers are full would make occ reach 3
    always @(negedge clk) if (rst_) chk("occ_le2", 32'(dut.occ <= 2'd2), 1);

    task automatic do_reset();
        rst_ = 1'b0;
        wr_ptr = '0;
        rd_ready = 1'b0;
`ifdef FIFO_RD_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    typedef struct {
        logic rn; logic [4:0] wr; logic rdy;
        logic ren; logic [3:0] raddr; logic rv; logic [7:0] d; logic [4:0] rp; logic e; logic [5:0] lvl;
    } vec_t;
    vec_t tbl [9];
    logic [7:0] pat [5];

    initial begin
        int sent, got, gaps, popped, exp_i, issued;
        logic wrapped, hold;
        logic [4:0] prev_rp;
        logic [7:0] hold_d;
        tbl[0] = '{1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 5'd0, 1'b1, 6'd0};
        tbl[1] = '{1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 5'd0, 1'b1, 6'd0};
        tbl[2] = '{1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 5'd0, 1'b1, 6'd0};
        tbl[3] = '{1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 5'd0, 1'b1, 6'd0};
        tbl[4] = '{1'b1, 5'd1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 5'd0, 1'b0, 6'd1};
        tbl[5] = '{1'b1, 5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 5'd1, 1'b0, 6'd1};
        tbl[6] = '{1'b1, 5'd1, 1'b1, 1'b0, 4'd1, 1'b1, 8'hA5, 5'd1, 1'b0, 6'd1};
        tbl[7] = '{1'b1, 5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 8'hA5, 5'd1, 1'b1, 6'd0};
        tbl[8] = '{1'b1, 5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 8'hA5, 5'd1, 1'b1, 6'd0};
        pat = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0};
        mem[0] = 8'hA5;
        // reset and single-word latency
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst_ = tbl[i].rn;
            wr_ptr = tbl[i].wr;
            rd_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_ren", i), 32'(mem_ren), 32'(tbl[i].ren));
            chk($sformatf("v%0d_raddr", i), 32'(mem_raddr), 32'(tbl[i].raddr));
            chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
            chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(tbl[i].d));
            chk($sformatf("v%0d_rdptr", i), 32'(rd_ptr), 32'(tbl[i].rp));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
        end
        // streaming with pointer wrap
        do_reset();
        rd_ready = 1'b1;
        sent = 0; got = 0; gaps = 0; wrapped = 1'b0; prev_rp = '0;
        for (int c = 0; c < 300 && got < 40; c++) begin
            @(negedge clk);
            if (sent < 40 && (wr_ptr - rd_ptr) < 5'd16) begin
                push(8'(sent));
                sent++;
            end
            #1;
            if (rd_valid) begin
                chk($sformatf("stream%0d", got), 32'(rd_data), 32'(got));
                got++;
            end else if (got > 0) gaps++;
            if (prev_rp == 5'd31 && rd_ptr == 5'd0) wrapped = 1'b1;
            prev_rp = rd_ptr;
        end
        chk("stream_count", 32'(got), 40);
        chk("stream_gaps", 32'(gaps), 0);
        chk("stream_wrap", 32'(wrapped), 1);
        chk("stream_rdptr", 32'(rd_ptr), 8);
        // backpressure
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        issued = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (mem_ren) issued++;
            if (rd_valid) chk("bp_hold", 32'(rd_data), 32'h10);
            @(negedge clk);
        end
        #1;
        chk("bp_issued", 32'(issued), 2);
        chk("bp_rdptr", 32'(rd_ptr), 2);
        chk("bp_valid", 32'(rd_valid), 1);
        chk("bp_data", 32'(rd_data), 32'h10);
        chk("bp_level", 32'(level), 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_drain_v%0d", i), 32'(rd_valid), 1);
            chk($sformatf("bp_drain_d%0d", i), 32'(rd_data), 32'(8'h10 + i));
            @(negedge clk);
            #1;
        end
        chk("bp_after_valid", 32'(rd_valid), 0);
        chk("bp_after_empty", 32'(empty), 1);
        // toggling ready
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        exp_i = 0; hold = 1'b0; hold_d = '0;
        for (int c = 0; c < 60 && exp_i < 8; c++) begin
            @(negedge clk);
            rd_ready = pat[c % 5][0];
            #1;
            if (hold) begin
                chk("tog_hold_v", 32'(rd_valid), 1);
                chk("tog_hold_d", 32'(rd_data), 32'(hold_d));
            end
            if (rd_valid && rd_ready) begin
                chk($sformatf("tog%0d", exp_i), 32'(rd_data), 32'(8'h20 + exp_i));
                exp_i++;
            end
            hold = rd_valid && !rd_ready;
            hold_d = rd_data;
        end
        chk("tog_count", 32'(exp_i), 8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rd_ready = 1'b1;
            #1;
            chk("tog_nodup", 32'(rd_valid), 0);
        end
        // abort mid-stream
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
        rd_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 40 && popped < 3; c++) begin
            @(negedge clk);
            #1;
            if (rd_valid) begin
                chk($sformatf("mid%0d", popped), 32'(rd_data), 32'(8'h30 + popped));
                popped++;
            end
        end
        chk("mid_popped", 32'(popped), 3);
`ifdef FIFO_RD_FLUSH_EN
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_ren", 32'(mem_ren), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_rdptr", 32'(rd_ptr), 32'(wr_ptr));
        chk("fl_valid", 32'(rd_valid), 0);
        chk("fl_level", 32'(level), 0);
        chk("fl_empty", 32'(empty), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("fl_late", 32'(rd_valid), 0);
        end
`else
        @(posedge clk);
        #2;
        rst_ = 1'b0;
        wr_ptr = '0;
        #1;
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_rdptr", 32'(rd_ptr), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_level", 32'(level), 0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rst_late_v", 32'(rd_valid), 0);
            chk("rst_late_ren", 32'(mem_ren), 0);
            chk("rst_late_lvl", 32'(level), 0);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
